// File: rtl/aes_pkg.sv
// Shared AES types and constants for the inverse cipher datapath.
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  // Byte-indexed view of a state: element 0 is the most significant byte.
  typedef logic [0:15][7:0] aes_bytes_t;

  localparam int AES_NUM_BYTES = 16;

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_e;

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational Rijndael inverse S-box: one byte in, one byte out.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  aes_byte_t data_byte,
  output aes_byte_t sub_byte
);

  // Row n of the literal below holds InvSbox(0xn0) .. InvSbox(0xnF).
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign sub_byte = INV_SBOX[data_byte];

endmodule

// File: rtl/aes_inv_sub_bytes.sv
// Iterative AES InvSubBytes engine, LANES bytes substituted per cycle.
// Define AES_INV_SHIFTROWS_EN to fuse InvShiftRows onto the output.
module aes_inv_sub_bytes
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  aes_state_t in_state,
  output logic       out_valid,
  input  logic       out_ready,
  output aes_state_t out_state,
  output logic       busy
);

  localparam int NUM_STEPS = AES_NUM_BYTES / LANES;
  localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  state_e           state;
  aes_bytes_t       st_q;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       base;
  aes_byte_t        lane_in  [LANES];
  aes_byte_t        lane_out [LANES];

  assign base = 4'(int'(cnt) * LANES);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_in[l] = st_q[base + 4'(l)];
    aes_inv_sbox u_sbox (
      .data_byte (lane_in[l]),
      .sub_byte  (lane_out[l])
    );
  end

  // In DONE a new state may be taken in the same cycle the result leaves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      st_q  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st_q  <= in_state;
            cnt   <= '0;
            state <= SUB;
          end
        end
        SUB: begin
          for (int l = 0; l < LANES; l++) begin
            st_q[base + 4'(l)] <= lane_out[l];
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(NUM_STEPS - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              st_q  <= in_state;
              cnt   <= '0;
              state <= SUB;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

`ifdef AES_INV_SHIFTROWS_EN
  // Row r rotates right by r columns: out[r][c] = st_q[r][(c-r) mod 4].
  aes_bytes_t shifted;
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shifted[4*c + r] = st_q[4*((c - r + 4) % 4) + r];
    end
  end
  assign out_state = shifted;
`else
  assign out_state = st_q;
`endif

endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// Directed self-checking bench for aes_inv_sub_bytes (LANES=4).
module tb_aes_inv_sub_bytes;
  import aes_pkg::*;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  aes_state_t in_state;
  logic       out_valid;
  logic       out_ready;
  aes_state_t out_state;
  logic       busy;

  int total = 0;
  int bad   = 0;

  aes_inv_sub_bytes #(.LANES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  // Present one state while idle; returns at the negedge after the accepting edge.
  task automatic send(input aes_state_t s);
    @(negedge clk);
    in_valid = 1'b1;
    in_state = s;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts clock edges until out_valid is seen, bounded.
  task automatic wait_done(input string tag, output int k);
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, 128'(out_valid), 128'(1));
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_low"}, 128'(out_valid), 128'(0));
    check({tag, "_in_ready"},  128'(in_ready),  128'(1));
  endtask

  int k;
  int xfers;
  aes_state_t held;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_state  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready",  128'(in_ready),  128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_state", out_state,       128'h0);
    check("rst_busy",      128'(busy),      128'(0));

    // All 0x63 -> all 0x00, latency 4
    send({16{8'h63}});
    check("t1_in_ready_sub", 128'(in_ready), 128'(0));
    check("t1_busy",         128'(busy),     128'(1));
    wait_done("t1", k);
    check("t1_latency", 128'(k), 128'(4));
    check("t1_state",   out_state, 128'h0);
    drain("t1");

    // Forward S-box of 0x00..0x0F
    send(128'h637C777BF26B6FC53001672BFED7AB76);
    wait_done("t2", k);
    check("t2_latency", 128'(k), 128'(4));
`ifdef AES_INV_SHIFTROWS_EN
    check("t2_state", out_state, 128'h000D0A0704010E0B0805020F0C090603);
`else
    check("t2_state", out_state, 128'h000102030405060708090A0B0C0D0E0F);
`endif
    drain("t2");

    // Backpressure: hold 10 cycles then accept once
    send({16{8'h52}});
    wait_done("t3", k);
    held = out_state;
    check("t3_state", held, {16{8'h48}});
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_state",    out_state,       {16{8'h48}});
      check("t3_hold_valid",    128'(out_valid), 128'(1));
      check("t3_hold_in_ready", 128'(in_ready),  128'(0));
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    xfers = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid && out_ready) xfers++;
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("t3_transfers", 128'(xfers), 128'(1));

    // Back-to-back: all 0x16 then all 0x00
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_state  = {16{8'h16}};
    @(posedge clk);
    @(negedge clk);
    in_state = {16{8'h00}};
    check("t4_in_ready_sub", 128'(in_ready), 128'(0));
    wait_done("t4a", k);
    check("t4a_latency",  128'(k),        128'(4));
    check("t4a_state",    out_state,      {16{8'hFF}});
    check("t4a_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_no_idle_busy",  128'(busy),      128'(1));
    check("t4_no_idle_valid", 128'(out_valid), 128'(0));
    wait_done("t4b", k);
    check("t4b_gap",   128'(k + 1), 128'(5));
    check("t4b_state", out_state,   {16{8'h52}});
    drain("t4b");
    check("t4_idle_busy", 128'(busy), 128'(0));

    // Reset at cnt=2 of SUB
    send({16{8'h63}});
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t5_rst_valid",    128'(out_valid), 128'(0));
    check("t5_rst_in_ready", 128'(in_ready),  128'(1));
    check("t5_rst_busy",     128'(busy),      128'(0));
    check("t5_rst_state",    out_state,       128'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t5_idle_valid", 128'(out_valid), 128'(0));
    check("t5_idle_busy",  128'(busy),      128'(0));
    send({16{8'h7C}});
    wait_done("t5", k);
    check("t5_latency", 128'(k), 128'(4));
    check("t5_state",   out_state, {16{8'h01}});
    drain("t5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
